// File: rtl/iq_oct.sv
// iq_oct: 8-entry issue-queue slice feeding an 8-way select-tree leaf.
// Entries wait for both source operands via tag-broadcast wakeup, raise a
// request when ready, and on a returned grant push their payload to register
// read and free themselves.
// Optional feature: define IQ_OCT_STALL_CNT_EN to add the 16-bit saturating
// stall_cnt_o counter of dispatch attempts made while the queue is full.
module iq_oct #(
    parameter int TAG_W     = 7,
    parameter int PAYLOAD_W = 32,
    parameter int N_WAKE    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    alloc_valid_i,
    input  logic [TAG_W-1:0]        alloc_src1_tag_i,
    input  logic                    alloc_src1_rdy_i,
    input  logic [TAG_W-1:0]        alloc_src2_tag_i,
    input  logic                    alloc_src2_rdy_i,
    input  logic [TAG_W-1:0]        alloc_dst_tag_i,
    input  logic [PAYLOAD_W-1:0]    alloc_payload_i,
    output logic                    alloc_ready_o,
    input  logic [N_WAKE-1:0]       wake_valid_i,
    input  logic [N_WAKE*TAG_W-1:0] wake_tag_i,
    output logic [7:0]              req_o,
    input  logic [7:0]              grant_i,
    output logic                    issue_valid_o,
    output logic [TAG_W-1:0]        issue_dst_tag_o,
    output logic [PAYLOAD_W-1:0]    issue_payload_o,
    output logic [3:0]              count_o
`ifdef IQ_OCT_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt_o
`endif
);

    // Per-entry control state
    logic [7:0] valid;
    logic [7:0] issued;
    logic [7:0] src1_rdy;
    logic [7:0] src2_rdy;

    // Per-entry data state (not reset; qualified by valid)
    logic [TAG_W-1:0]     src1_tag [8];
    logic [TAG_W-1:0]     src2_tag [8];
    logic [TAG_W-1:0]     dst_tag  [8];
    logic [PAYLOAD_W-1:0] payload  [8];

    logic       alloc_fire;
    logic [2:0] alloc_idx;
    logic       alloc_s1_rdy;
    logic       alloc_s2_rdy;
    logic [7:0] honoured;
    logic       grant_fire;
    logic [2:0] grant_idx;
    // Debug flag: more than one honoured grant in a cycle (select tree bug).
    logic       grant_conflict;

    // True when any valid wakeup port broadcasts the given tag.
    function automatic logic wake_hit(input logic [TAG_W-1:0]        tag,
                                      input logic [N_WAKE-1:0]       vld,
                                      input logic [N_WAKE*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N_WAKE; k++) begin
            if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

    // Requests, allocation slot, grant arbitration and occupancy from state.
    always_comb begin
        req_o = '0;
        for (int i = 0; i < 8; i++) begin
            req_o[i] = valid[i] & ~issued[i] & src1_rdy[i] & src2_rdy[i];
        end
        alloc_ready_o  = ~&valid;
        alloc_fire     = alloc_valid_i & alloc_ready_o;
        alloc_idx      = lowest_set(~valid);
        alloc_s1_rdy   = alloc_src1_rdy_i | wake_hit(alloc_src1_tag_i, wake_valid_i, wake_tag_i);
        alloc_s2_rdy   = alloc_src2_rdy_i | wake_hit(alloc_src2_tag_i, wake_valid_i, wake_tag_i);
        honoured       = grant_i & req_o;
        grant_fire     = |honoured;
        grant_idx      = lowest_set(honoured);
        grant_conflict = (honoured & (honoured - 8'd1)) != 8'd0;
        count_o        = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'd0, valid[i]};
        end
    end

    // Entry control: free on grant, fill on alloc, sticky wakeup of ready bits.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid  <= '0;
            issued <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (valid[i] && wake_hit(src1_tag[i], wake_valid_i, wake_tag_i)) begin
                    src1_rdy[i] <= 1'b1;
                end
                if (valid[i] && wake_hit(src2_tag[i], wake_valid_i, wake_tag_i)) begin
                    src2_rdy[i] <= 1'b1;
                end
                // issued is cleared together with valid, so it never holds a request back
                if (grant_fire && (grant_idx == i[2:0])) begin
                    valid[i]  <= 1'b0;
                    issued[i] <= 1'b0;
                end
                if (alloc_fire && (alloc_idx == i[2:0])) begin
                    valid[i]    <= 1'b1;
                    issued[i]   <= 1'b0;
                    src1_rdy[i] <= alloc_s1_rdy;
                    src2_rdy[i] <= alloc_s2_rdy;
                end
            end
        end
    end

    // Entry data capture on allocation.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            src1_tag[alloc_idx] <= alloc_src1_tag_i;
            src2_tag[alloc_idx] <= alloc_src2_tag_i;
            dst_tag[alloc_idx]  <= alloc_dst_tag_i;
            payload[alloc_idx]  <= alloc_payload_i;
        end
    end

    // Issue register: one-cycle grant-to-issue, holds data when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_valid_o   <= 1'b0;
            issue_dst_tag_o <= '0;
            issue_payload_o <= '0;
        end else if (flush_i) begin
            issue_valid_o <= 1'b0;
        end else begin
            issue_valid_o <= grant_fire;
            if (grant_fire) begin
                issue_dst_tag_o <= dst_tag[grant_idx];
                issue_payload_o <= payload[grant_idx];
            end
        end
    end

    // Flags a select tree that returned more than one honoured grant.
    cover property (@(posedge clk_i) disable iff (rst_i) grant_conflict);

`ifdef IQ_OCT_STALL_CNT_EN
    // Saturating count of dispatch attempts rejected because the queue is full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= 16'd0;
        end else if (alloc_valid_i && !alloc_ready_o && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iq_oct.sv
// Directed testbench for iq_oct with hand-computed expectations.
module tb_iq_oct;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        alloc_valid_i;
    logic [6:0]  alloc_src1_tag_i;
    logic        alloc_src1_rdy_i;
    logic [6:0]  alloc_src2_tag_i;
    logic        alloc_src2_rdy_i;
    logic [6:0]  alloc_dst_tag_i;
    logic [31:0] alloc_payload_i;
    logic        alloc_ready_o;
    logic [1:0]  wake_valid_i;
    logic [13:0] wake_tag_i;
    logic [7:0]  req_o;
    logic [7:0]  grant_i;
    logic        issue_valid_o;
    logic [6:0]  issue_dst_tag_o;
    logic [31:0] issue_payload_o;
    logic [3:0]  count_o;
`ifdef IQ_OCT_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    iq_oct dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_src1_tag_i (alloc_src1_tag_i),
        .alloc_src1_rdy_i (alloc_src1_rdy_i),
        .alloc_src2_tag_i (alloc_src2_tag_i),
        .alloc_src2_rdy_i (alloc_src2_rdy_i),
        .alloc_dst_tag_i  (alloc_dst_tag_i),
        .alloc_payload_i  (alloc_payload_i),
        .alloc_ready_o    (alloc_ready_o),
        .wake_valid_i     (wake_valid_i),
        .wake_tag_i       (wake_tag_i),
        .req_o            (req_o),
        .grant_i          (grant_i),
        .issue_valid_o    (issue_valid_o),
        .issue_dst_tag_o  (issue_dst_tag_o),
        .issue_payload_o  (issue_payload_o),
        .count_o          (count_o)
`ifdef IQ_OCT_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i          = 1'b0;
        alloc_valid_i    = 1'b0;
        alloc_src1_tag_i = '0;
        alloc_src1_rdy_i = 1'b0;
        alloc_src2_tag_i = '0;
        alloc_src2_rdy_i = 1'b0;
        alloc_dst_tag_i  = '0;
        alloc_payload_i  = '0;
        wake_valid_i     = '0;
        wake_tag_i       = '0;
        grant_i          = '0;
    endtask

    task automatic alloc(input logic [6:0] s1, input logic r1, input logic [6:0] s2,
                         input logic r2, input logic [6:0] dst, input logic [31:0] pay);
        alloc_valid_i    = 1'b1;
        alloc_src1_tag_i = s1;
        alloc_src1_rdy_i = r1;
        alloc_src2_tag_i = s2;
        alloc_src2_rdy_i = r2;
        alloc_dst_tag_i  = dst;
        alloc_payload_i  = pay;
        step();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        check("rst_count", count_o, 0);
        check("rst_req", req_o, 0);
        check("rst_issue_valid", issue_valid_o, 0);
        check("rst_issue_payload", issue_payload_o, 0);
        check("rst_issue_dst", issue_dst_tag_o, 0);
        check("rst_alloc_ready", alloc_ready_o, 1);

        // Fill all 8 entries with ready sources
        for (int i = 0; i < 8; i++) begin
            alloc(7'h01, 1'b1, 7'h02, 1'b1, 7'h40 + 7'(i), 32'hA000_0000 + i);
        end
        check("fill_count", count_o, 8);
        check("fill_req", req_o, 8'hFF);
        check("fill_alloc_ready", alloc_ready_o, 0);
        alloc(7'h01, 1'b1, 7'h02, 1'b1, 7'h7E, 32'hBAD0_0009);
        check("full_alloc_ignored", count_o, 8);
`ifdef IQ_OCT_STALL_CNT_EN
        check("stall_cnt", stall_cnt_o, 1);
`endif
        flush_i = 1'b1;
        step();
        idle();
        check("flush_count", count_o, 0);
        check("flush_req", req_o, 0);

        // Late wakeup on port 1
        alloc(7'h15, 1'b0, 7'h03, 1'b1, 7'h11, 32'hDEAD_0001);
        check("wait_req0", req_o, 0);
        check("wait_count", count_o, 1);
        step();
        check("wait_req1", req_o, 0);
        wake_valid_i = 2'b10;
        wake_tag_i   = {7'h15, 7'h00};
        step();
        idle();
        check("wake_req", req_o, 8'h01);
        grant_i = 8'h01;
        step();
        idle();
        check("grant_issue_valid", issue_valid_o, 1);
        check("grant_issue_payload", issue_payload_o, 32'hDEAD_0001);
        check("grant_issue_dst", issue_dst_tag_o, 7'h11);
        check("grant_count", count_o, 0);
        step();
        check("idle_issue_valid", issue_valid_o, 0);
        check("idle_payload_hold", issue_payload_o, 32'hDEAD_0001);

        // Same-cycle wakeup on port 0 during allocation
        wake_valid_i = 2'b01;
        wake_tag_i   = {7'h00, 7'h22};
        alloc(7'h04, 1'b1, 7'h22, 1'b0, 7'h12, 32'hDEAD_0002);
        check("samewake_req", req_o, 8'h01);
        grant_i = 8'h01;
        step();
        idle();
        check("samewake_payload", issue_payload_o, 32'hDEAD_0002);
        check("samewake_count", count_o, 0);

        // Full queue: grant and alloc in the same cycle
        for (int i = 0; i < 8; i++) begin
            alloc(7'h01, 1'b1, 7'h02, 1'b1, 7'h50 + 7'(i), 32'hB000_0000 + i);
        end
        grant_i          = 8'h10;
        alloc_valid_i    = 1'b1;
        alloc_src1_rdy_i = 1'b1;
        alloc_src2_rdy_i = 1'b1;
        alloc_dst_tag_i  = 7'h7F;
        alloc_payload_i  = 32'hC0DE_0009;
        check("full_grant_alloc_ready", alloc_ready_o, 0);
        step();
        idle();
        check("fg_issue_valid", issue_valid_o, 1);
        check("fg_issue_payload", issue_payload_o, 32'hB000_0004);
        check("fg_issue_dst", issue_dst_tag_o, 7'h54);
        check("fg_count", count_o, 7);
        check("fg_alloc_ready", alloc_ready_o, 1);
        check("fg_req", req_o, 8'hEF);
        alloc(7'h01, 1'b1, 7'h02, 1'b1, 7'h3C, 32'hCCCC_0004);
        check("refill_count", count_o, 8);
        check("refill_req", req_o, 8'hFF);
        grant_i = 8'h10;
        step();
        idle();
        check("refill_slot4_payload", issue_payload_o, 32'hCCCC_0004);
        check("refill_slot4_dst", issue_dst_tag_o, 7'h3C);
        flush_i = 1'b1;
        step();
        idle();

        // Flush beats a same-cycle grant
        for (int i = 0; i < 3; i++) begin
            alloc(7'h01, 1'b1, 7'h02, 1'b1, 7'h20 + 7'(i), 32'hD000_0000 + i);
        end
        check("three_count", count_o, 3);
        check("three_req", req_o, 8'h07);
        flush_i = 1'b1;
        grant_i = 8'h02;
        step();
        idle();
        check("fl_count", count_o, 0);
        check("fl_req", req_o, 0);
        check("fl_issue_valid", issue_valid_o, 0);
        check("fl_payload_hold", issue_payload_o, 32'hCCCC_0004);

        // Multi-grant: lowest index wins and the conflict flag rises
        for (int i = 0; i < 3; i++) begin
            alloc(7'h01, 1'b1, 7'h02, 1'b1, 7'h60 + 7'(i), 32'hE000_0000 + i);
        end
        grant_i = 8'h06;
        #1;
        check("conflict_flag", {31'd0, dut.grant_conflict}, 1);
        step();
        idle();
        check("mg_issue_valid", issue_valid_o, 1);
        check("mg_issue_payload", issue_payload_o, 32'hE000_0001);
        check("mg_issue_dst", issue_dst_tag_o, 7'h61);
        check("mg_count", count_o, 2);
        check("mg_req", req_o, 8'h05);
        // Grant to an invalid entry is ignored
        grant_i = 8'h80;
        #1;
        check("noconflict_flag", {31'd0, dut.grant_conflict}, 0);
        step();
        idle();
        check("bad_grant_issue_valid", issue_valid_o, 0);
        check("bad_grant_count", count_o, 2);
        check("bad_grant_payload_hold", issue_payload_o, 32'hE000_0001);

        // Reset mid-operation
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_count", count_o, 0);
        check("midrst_req", req_o, 0);
        check("midrst_payload", issue_payload_o, 0);
        check("midrst_dst", issue_dst_tag_o, 0);
        check("midrst_alloc_ready", alloc_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
